// File: rtl/state_word_serializer_pkg.sv
// Shared types and constants for the AES state-to-word serializer.
package state_word_serializer_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_e;

   // Word-index width; a single-word block still needs one index bit.
   function automatic int idx_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/state_word_serializer_select.sv
// Combinational word picker: column idx of the buffer, or row idx of the 4x4 byte matrix.
module state_word_select
   import state_word_serializer_pkg::*;
#(
   parameter  int SIZE  = 128,
   localparam int WORDS = SIZE / WORD_W,
   localparam int IDX_W = idx_width(WORDS)
) (
   input  logic [SIZE-1:0]  buf_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic             row_mode_i,
   output word_t            word_o
);

   word_t col_word;

   assign col_word = buf_i[idx_i*WORD_W +: WORD_W];

   generate
      if (SIZE == 128) begin : g_row
         word_t row_word;

         // Byte c of the row word is byte idx of column c.
         for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign row_word[gi*BYTE_W +: BYTE_W] = buf_i[gi*WORD_W + idx_i*BYTE_W +: BYTE_W];
         end

         assign word_o = row_mode_i ? row_word : col_word;
      end else begin : g_no_row
         logic unused_row_mode;

         assign unused_row_mode = row_mode_i;
         assign word_o          = col_word;
      end
   endgenerate

endmodule

// File: rtl/state_word_serializer.sv
// Unpacks one SIZE-bit AES state per handshake into WORDS 32-bit words, column or row order.
module state_word_serializer
   import state_word_serializer_pkg::*;
#(
   parameter  int SIZE  = 128,
   localparam int WORDS = SIZE / WORD_W,
   localparam int IDX_W = idx_width(WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SIZE-1:0]  in_block,
   input  logic             in_row_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output word_t            out_word,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
   localparam bit               ROW_OK   = (SIZE == 128);

   ser_state_e       state_q, state_d;
   logic [SIZE-1:0]  buf_q, buf_d;
   logic             row_q, row_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             out_fire;
   logic             accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SER_IDLE;
         buf_q   <= '0;
         row_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         row_q   <= row_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      out_valid = (state_q == SER_SEND);
      out_last  = out_valid && (idx_q == LAST_IDX);
      out_fire  = out_valid && out_ready;
      // Ready during the final handshake lets the next block follow with no bubble.
      in_ready  = (state_q == SER_IDLE) || (out_fire && out_last);
      accept    = in_valid && in_ready;

      state_d = state_q;
      buf_d   = buf_q;
      row_d   = row_q;
      idx_d   = idx_q;

      if (accept) begin
         state_d = SER_SEND;
         buf_d   = in_block;
         row_d   = in_row_mode && ROW_OK;
         idx_d   = '0;
      end else if (out_fire) begin
         if (out_last) begin
            state_d = SER_IDLE;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   assign out_idx = idx_q;

   state_word_select #(
      .SIZE(SIZE)
   ) u_select (
      .buf_i      (buf_q),
      .idx_i      (idx_q),
      .row_mode_i (row_q),
      .word_o     (out_word)
   );

endmodule

// File: tb/tb_state_word_serializer.sv
// Scoreboard bench for state_word_serializer: expected words are queued on accept, popped on handshake.
module tb_state_word_serializer;
   import state_word_serializer_pkg::*;

   logic         clk         = 1'b0;
   logic         rst         = 1'b1;
   logic         in_valid    = 1'b0;
   logic         in_ready;
   logic [127:0] in_block    = '0;
   logic         in_row_mode = 1'b0;
   logic         out_valid;
   logic         out_ready   = 1'b0;
   word_t        out_word;
   logic [1:0]   out_idx;
   logic         out_last;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      word_t      word;
      logic [1:0] idx;
      logic       last;
   } exp_t;

   exp_t sb[$];

   localparam logic [127:0] PLAN_BLOCK = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   word_t col_exp [4] = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
   word_t row_exp [4] = '{32'h3377BBFF, 32'h2266AAEE, 32'h115599DD, 32'h004488CC};

   always #5 clk = ~clk;

   state_word_serializer #(
      .SIZE(128)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_block    (in_block),
      .in_row_mode (in_row_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_word    (out_word),
      .out_idx     (out_idx),
      .out_last    (out_last)
   );

   function automatic word_t model_word(input logic [127:0] blk, input logic row, input int i);
      word_t w;
      w = '0;
      if (!row) begin
         w = blk[i*32 +: 32];
      end else begin
         for (int c = 0; c < 4; c++) begin
            w[c*8 +: 8] = blk[c*32 + i*8 +: 8];
         end
      end
      return w;
   endfunction

   function automatic logic [127:0] rand_block();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic push_block(input logic [127:0] blk, input logic row);
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         e.word = model_word(blk, row, i);
         e.idx  = 2'(i);
         e.last = (i == 3);
         sb.push_back(e);
      end
   endtask

   task automatic test_reset();
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 2'd0 ||
          out_last !== 1'b0 || out_word !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset: valid=%b ready=%b idx=%0d last=%b word=%h required 0 1 0 0 00000000",
                  out_valid, in_ready, out_idx, out_last, out_word);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      $display("[TB] reset released");
   endtask

   task automatic test_idle();
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         tests_run++;
         if (out_valid !== 1'b0 || out_word !== 32'h0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle cycle %0d: valid=%b word=%h ready=%b required 0 00000000 1",
                     cyc, out_valid, out_word, in_ready);
         end
      end
      $display("[TB] idle hold 10 cycles done");
   endtask

   // One block with out_ready held high: word k must appear k+1 cycles after accept.
   task automatic test_stream(input string name, input logic [127:0] blk, input logic row,
                              input word_t exp_w [4]);
      exp_t e;
      @(negedge clk);
      in_block    = blk;
      in_row_mode = row;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
      end
      for (int i = 0; i < 4; i++) begin
         e.word = exp_w[i];
         e.idx  = 2'(i);
         e.last = (i == 3);
         sb.push_back(e);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid    = 1'b0;
         in_block    = rand_block();
         in_row_mode = ~row;
         #1;
         e = sb.pop_front();
         tests_run++;
         if (out_valid !== 1'b1 || out_word !== e.word || out_idx !== e.idx || out_last !== e.last) begin
            tests_failed++;
            $display("FAIL %s word %0d: valid=%b word=%h idx=%0d last=%b required 1 %h %0d %b",
                     name, i, out_valid, out_word, out_idx, out_last, e.word, e.idx, e.last);
         end else begin
            $display("[TB] %s word %0d: %h idx=%0d last=%b", name, i, out_word, out_idx, out_last);
         end
      end
      @(negedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s end: out_valid=%b required 0", name, out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] blk;
      logic         pat [4];
      int           hs;
      int           cyc;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      hs  = 0;
      cyc = 0;
      blk = rand_block();
      @(negedge clk);
      in_block    = blk;
      in_row_mode = 1'b0;
      in_valid    = 1'b1;
      out_ready   = 1'b0;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL backpressure accept: in_ready=%b required 1", in_ready);
      end
      push_block(blk, 1'b0);
      while (hs < 4 && cyc < 24) begin
         @(negedge clk);
         in_valid  = !sb[0].last;
         in_block  = rand_block();
         out_ready = pat[cyc % 4];
         #1;
         tests_run++;
         if (out_valid !== 1'b1 || out_word !== sb[0].word || out_idx !== sb[0].idx ||
             out_last !== sb[0].last || in_ready !== (out_ready && sb[0].last)) begin
            tests_failed++;
            $display("FAIL backpressure cycle %0d: valid=%b word=%h idx=%0d last=%b in_ready=%b required 1 %h %0d %b %b",
                     cyc, out_valid, out_word, out_idx, out_last, in_ready,
                     sb[0].word, sb[0].idx, sb[0].last, out_ready && sb[0].last);
         end
         if (out_ready) begin
            $display("[TB] backpressure handshake %0d: %h idx=%0d", hs, out_word, out_idx);
            void'(sb.pop_front());
            hs++;
         end
         cyc++;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      tests_run++;
      if (hs != 4 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL backpressure end: handshakes=%0d valid=%b required 4 0", hs, out_valid);
      end
      sb.delete();
   endtask

   task automatic test_back_to_back();
      logic [127:0] b1;
      logic [127:0] b2;
      int           accepts;
      int           acc2_cyc;
      logic         exp_rdy;
      exp_t         e;
      b1       = rand_block();
      b2       = rand_block();
      accepts  = 0;
      acc2_cyc = -1;
      @(negedge clk);
      in_block    = b1;
      in_row_mode = 1'b0;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b accept1: in_ready=%b required 1", in_ready);
      end
      push_block(b1, 1'b0);
      accepts = 1;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         in_valid    = (accepts < 2);
         in_row_mode = 1'b1;
         in_block    = (cyc == 4) ? b2 : rand_block();
         #1;
         if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL b2b cycle %0d: scoreboard empty, valid=%b", cyc, out_valid);
            break;
         end
         exp_rdy = sb[0].last;
         e       = sb.pop_front();
         tests_run++;
         if (out_valid !== 1'b1 || out_word !== e.word || out_idx !== e.idx ||
             out_last !== e.last || in_ready !== exp_rdy) begin
            tests_failed++;
            $display("FAIL b2b cycle %0d: valid=%b word=%h idx=%0d last=%b in_ready=%b required 1 %h %0d %b %b",
                     cyc, out_valid, out_word, out_idx, out_last, in_ready, e.word, e.idx, e.last, exp_rdy);
         end else begin
            $display("[TB] b2b cycle %0d: %h idx=%0d last=%b", cyc, out_word, out_idx, out_last);
         end
         if (in_valid && in_ready) begin
            push_block(b2, 1'b1);
            accepts++;
            acc2_cyc = cyc;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (acc2_cyc != 4 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b end: second accept cycle=%0d valid=%b required 4 0", acc2_cyc, out_valid);
      end
      sb.delete();
   endtask

   task automatic test_reset_mid();
      logic [127:0] blk;
      logic [127:0] blk2;
      word_t        w [4];
      exp_t         e;
      blk  = rand_block();
      blk2 = rand_block();
      @(negedge clk);
      in_block    = blk;
      in_row_mode = 1'b1;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      #1;
      push_block(blk, 1'b1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         e = sb.pop_front();
         tests_run++;
         if (out_valid !== 1'b1 || out_word !== e.word || out_idx !== e.idx) begin
            tests_failed++;
            $display("FAIL reset_mid word %0d: valid=%b word=%h idx=%0d required 1 %h %0d",
                     i, out_valid, out_word, out_idx, e.word, e.idx);
         end else begin
            $display("[TB] reset_mid word %0d: %h idx=%0d", i, out_word, out_idx);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 2'd0 ||
          out_last !== 1'b0 || out_word !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_mid async: valid=%b ready=%b idx=%0d last=%b word=%h required 0 1 0 0 00000000",
                  out_valid, in_ready, out_idx, out_last, out_word);
      end
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid release: out_valid=%b required 0", out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         w[i] = model_word(blk2, 1'b0, i);
      end
      test_stream("after_reset", blk2, 1'b0, w);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_idle();
      test_stream("column", PLAN_BLOCK, 1'b0, col_exp);
      test_stream("row", PLAN_BLOCK, 1'b1, row_exp);
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
